md_unit: RTL

Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It sits beside the ALU, directly downstream of the grf read ports. It takes rs/rt operands (A, RD2) plus a decoded operation from the controller, and produces HI/LO for the writeback mux (mfhi/mflo). It exposes `busy` so that issue logic can stall any instruction that touches HI/LO while an operation is in flight.

---
 rtl/md_unit_if.sv | 38 +++
 rtl/md_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/md_unit_if.sv
// ============================================================================
// Module      : md_unit_if
// Description : Issue/result bundle between the MIPS issue stage and the
//               multiply/divide unit.
//                 start  - qualifies md_op for the current cycle
//                 md_op  - 0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                          5 mthi, 6 mtlo, 7 reserved
//                 A, B   - rs / rt operands
//                 busy   - operation in flight, HI/LO not yet valid
//                 done   - one-cycle pulse after a mult/div result lands
//                 hi, lo - architectural HI/LO registers
//               master: issue side, slave: md_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface md_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, A, B,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, md_op, A, B,
    output busy, done, hi, lo
  );
endinterface

`default_nettype wire

// File: rtl/md_unit.sv
// ============================================================================
// Module      : md_unit
// Description : Multi-cycle multiply/divide unit with architectural HI/LO.
//               mult/multu occupy MULT_CYCLES cycles, div/divu occupy
//               DIV_CYCLES cycles; mthi/mtlo write in the accepting edge.
//               Ports:
//                 clk   - system clock, rising edge
//                 reset - asynchronous, active-high; clears all state
//                 bus   - md_unit_if.slave (start, md_op, A, B in;
//                         busy, done, hi, lo out, all registered)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  wire logic  clk,
  input  wire logic  reset,
  md_unit_if.slave   bus
);

  localparam logic [2:0] c_OP_MULT  = 3'd1;
  localparam logic [2:0] c_OP_MULTU = 3'd2;
  localparam logic [2:0] c_OP_DIV   = 3'd3;
  localparam logic [2:0] c_OP_DIVU  = 3'd4;
  localparam logic [2:0] c_OP_MTHI  = 3'd5;
  localparam logic [2:0] c_OP_MTLO  = 3'd6;

  localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

  localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [2:0]           r_op;
  logic [31:0]          r_a;
  logic [31:0]          r_b;
  logic [31:0]          r_hi;
  logic [31:0]          r_lo;
  logic                 r_busy;
  logic                 r_done;

  // --------------------------------------------------------------------------
  // Arithmetic on the latched operands only; inputs on the bus are ignored
  // while the operation runs.
  // --------------------------------------------------------------------------
  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;
  logic               w_a_neg;
  logic               w_b_neg;
  logic        [31:0] w_abs_a;
  logic        [31:0] w_abs_b;
  logic               w_div_zero;
  logic        [31:0] w_den_s;
  logic        [31:0] w_den_u;
  logic        [31:0] w_q_mag;
  logic        [31:0] w_r_mag;
  logic        [31:0] w_q_s;
  logic        [31:0] w_r_s;
  logic        [31:0] w_q_u;
  logic        [31:0] w_r_u;

  assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

  // Signed divide is done on magnitudes so that 0x80000000 / -1 needs no
  // special case: |0x80000000| is 0x80000000 as an unsigned magnitude, and
  // negating that quotient wraps back to 0x80000000.
  assign w_a_neg    = r_a[31];
  assign w_b_neg    = r_b[31];
  assign w_abs_a    = w_a_neg ? (~r_a + 32'd1) : r_a;
  assign w_abs_b    = w_b_neg ? (~r_b + 32'd1) : r_b;
  assign w_div_zero = (r_b == 32'd0);

  // Substitute a divisor of 1 on divide-by-zero; the result is discarded
  // anyway, this just keeps the divider free of undefined values.
  assign w_den_s = w_div_zero ? 32'd1 : w_abs_b;
  assign w_den_u = w_div_zero ? 32'd1 : r_b;

  assign w_q_mag = w_abs_a / w_den_s;
  assign w_r_mag = w_abs_a % w_den_s;
  assign w_q_s   = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_r_s   = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

  assign w_q_u = r_a / w_den_u;
  assign w_r_u = r_a % w_den_u;

  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_res_we;

  always_comb begin
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    w_res_we = 1'b0;
    case (r_op)
      c_OP_MULT: begin
        w_res_hi = w_prod_s[63:32];
        w_res_lo = w_prod_s[31:0];
        w_res_we = 1'b1;
      end
      c_OP_MULTU: begin
        w_res_hi = w_prod_u[63:32];
        w_res_lo = w_prod_u[31:0];
        w_res_we = 1'b1;
      end
      c_OP_DIV: begin
        w_res_hi = w_r_s;
        w_res_lo = w_q_s;
        w_res_we = !w_div_zero;
      end
      c_OP_DIVU: begin
        w_res_hi = w_r_u;
        w_res_lo = w_q_u;
        w_res_we = !w_div_zero;
      end
      default: begin
        w_res_we = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Control FSM. The counter is loaded with N on acceptance and the result
  // lands on the edge where it is 1, giving exactly N busy cycles.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= 3'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.md_op)
              c_OP_MULT, c_OP_MULTU: begin
                r_op    <= bus.md_op;
                r_a     <= bus.A;
                r_b     <= bus.B;
                r_cnt   <= c_MULT_LOAD;
                r_state <= S_RUN;
                r_busy  <= 1'b1;
              end
              c_OP_DIV, c_OP_DIVU: begin
                r_op    <= bus.md_op;
                r_a     <= bus.A;
                r_b     <= bus.B;
                r_cnt   <= c_DIV_LOAD;
                r_state <= S_RUN;
                r_busy  <= 1'b1;
              end
              c_OP_MTHI: r_hi <= bus.A;
              c_OP_MTLO: r_lo <= bus.A;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          // start is deliberately not examined here: requests made while
          // busy are dropped, not queued.
          if (r_cnt == c_CNT_LAST) begin
            if (w_res_we) begin
              r_hi <= w_res_hi;
              r_lo <= w_res_lo;
            end
            r_cnt   <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - c_CNT_LAST;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

`default_nettype wire
